vm_ctrl_param: RTL and testbench



---
 rtl/vm_ctrl_param_pkg.sv | 40 ++++
 rtl/vm_coin_timer.sv | 40 ++++
 rtl/vm_ctrl_param.sv | 276 +++++++++++++++++++++++++++
 tb/tb_vm_ctrl_param.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_ctrl_param_pkg.sv
// Shared types for the parametrised vending-machine controller:
// controller states, front-panel status codes and coin encodings.
package vm_ctrl_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_COLLECT = 3'd2,
    S_VEND    = 3'd3,
    S_REFUND  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE         = 2'd0,
    ST_AVAILABLE    = 2'd1,
    ST_OUT_OF_STOCK = 2'd2,
    ST_INSUFFICIENT = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    COIN_INVALID = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_e;

  // Wide enough for the largest coin (25 cents).
  localparam int COIN_VAL_W = 5;

  // Face value of a coin in cents; an invalid code is worth nothing.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_e c);
    case (c)
      COIN_NICKEL:  return 5'd5;
      COIN_DIME:    return 5'd10;
      COIN_QUARTER: return 5'd25;
      default:      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_coin_timer.sv
// Idle timer for the coin-collection phase: loads TIMEOUT, counts down
// towards zero and flags when it has run out.
module vm_coin_timer
  import vm_ctrl_param_pkg::*;
#(
  parameter int TIMEOUT = 255,
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic hrst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Reload wins over decrement; the count saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(TIMEOUT);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  // Counter register, starts full out of reset.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      count_q <= TW'(TIMEOUT);
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/vm_ctrl_param.sv
// Vending-machine controller: selection check, coin collection with idle
// timeout, dispense with change, refund, and supplier restock of the
// per-slot stock and price tables.
module vm_ctrl_param
  import vm_ctrl_param_pkg::*;
#(
  parameter int N_ITEMS       = 8,
  parameter int CAP           = 16,
  parameter int PRICE_W       = 16,
  parameter int TIMEOUT       = 255,
  parameter int DEFAULT_PRICE = 50,
  localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
  localparam int SW = $clog2(CAP + 1)
) (
  input  logic               clk,
  input  logic               hrst_n,
  input  logic               srst,
  input  logic               sel_valid,
  input  logic [IW-1:0]      sel_idx,
  input  logic               coin_valid,
  input  logic [1:0]         coin,
  input  logic               confirm,
  input  logic               cancel,
  input  logic               restock_valid,
  input  logic [IW-1:0]      restock_idx,
  input  logic [SW-1:0]      restock_count,
  input  logic [PRICE_W-1:0] restock_price,
  output logic [1:0]         status,
  output logic [PRICE_W-1:0] price_out,
  output logic [PRICE_W-1:0] credit,
  output logic               coin_rej,
  output logic               vend_valid,
  output logic [IW-1:0]      vend_idx,
  output logic               change_valid,
  output logic [PRICE_W-1:0] change_amt,
  output logic               restock_ack,
  output logic               restock_err,
  output logic               busy
);

  // Money is handled one bit wider than PRICE_W so overflow and borrow
  // are visible; stock likewise one bit wider than SW.
  localparam int CW = PRICE_W + 1;
  localparam int SX = SW + 1;

  state_e             state_q, state_d;
  status_e            status_q, status_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [PRICE_W-1:0] price_out_q, price_out_d;
  logic [PRICE_W-1:0] credit_q, credit_d;
  logic [PRICE_W-1:0] change_amt_q, change_amt_d;
  logic [IW-1:0]      vend_idx_q, vend_idx_d;
  logic               coin_rej_q, coin_rej_d;
  logic               vend_valid_q, vend_valid_d;
  logic               change_valid_q, change_valid_d;
  logic               restock_ack_q, restock_ack_d;
  logic               restock_err_q, restock_err_d;
  logic               busy_q, busy_d;

  logic [SW-1:0]      stock_q [N_ITEMS];
  logic [SW-1:0]      stock_d [N_ITEMS];
  logic [PRICE_W-1:0] price_q [N_ITEMS];
  logic [PRICE_W-1:0] price_d [N_ITEMS];

  logic               sel_ok, rs_ok;
  logic [IW-1:0]      sel_rd, rs_rd;
  logic [CW-1:0]      coin_val, coin_sum, change_diff;
  logic               coin_ok, change_pos;
  logic [SX-1:0]      restock_sum, stock_dec;
  logic               timer_load, timer_dec, timer_zero;

  // When N_ITEMS is a power of two every index is a real slot, so the
  // range check would be constant; only build it when it can fail.
  if (N_ITEMS == (1 << IW)) begin : g_idx_pow2
    assign sel_ok = 1'b1;
    assign rs_ok  = 1'b1;
  end else begin : g_idx_range
    assign sel_ok = (int'(sel_q) < N_ITEMS);
    assign rs_ok  = (int'(restock_idx) < N_ITEMS);
  end

  // Table reads always use an in-range index.
  assign sel_rd = sel_ok ? sel_q : '0;
  assign rs_rd  = rs_ok ? restock_idx : '0;

  assign coin_val    = CW'(coin_value(coin_e'(coin)));
  assign coin_sum    = {1'b0, credit_q} + coin_val;
  assign coin_ok     = (coin_val != '0) && !coin_sum[PRICE_W];
  assign change_diff = {1'b0, credit_q} - {1'b0, price_out_q};
  assign change_pos  = !change_diff[PRICE_W] && (change_diff[PRICE_W-1:0] != '0);
  assign restock_sum = {1'b0, stock_q[rs_rd]} + {1'b0, restock_count};
  assign stock_dec   = {1'b0, stock_q[sel_rd]} - SX'(1);

  vm_coin_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .hrst_n (hrst_n),
    .load   (timer_load),
    .dec    (timer_dec),
    .zero   (timer_zero)
  );

  // Next-state, table updates and pulse outputs for the controller.
  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    sel_d          = sel_q;
    price_out_d    = price_out_q;
    credit_d       = credit_q;
    change_amt_d   = change_amt_q;
    vend_idx_d     = vend_idx_q;
    coin_rej_d     = 1'b0;
    vend_valid_d   = 1'b0;
    change_valid_d = 1'b0;
    restock_ack_d  = 1'b0;
    restock_err_d  = 1'b0;
    stock_d        = stock_q;
    price_d        = price_q;
    timer_load     = 1'b0;
    timer_dec      = 1'b0;

    // Coins are only taken while collecting; anywhere else they bounce.
    if (coin_valid && (state_q != S_COLLECT)) begin
      coin_rej_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (restock_valid) begin
          if (!rs_ok || (restock_sum > SX'(CAP))) begin
            restock_err_d = 1'b1;
          end else begin
            restock_ack_d = 1'b1;
            stock_d[rs_rd] = restock_sum[SW-1:0];
            if (restock_price != '0) begin
              price_d[rs_rd] = restock_price;
            end
          end
        end else if (sel_valid) begin
          sel_d   = sel_idx;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (srst) begin
          state_d = S_IDLE;
        end else if (!sel_ok || (stock_q[sel_rd] == '0)) begin
          status_d = ST_OUT_OF_STOCK;
          state_d  = S_IDLE;
        end else begin
          status_d    = ST_AVAILABLE;
          price_out_d = price_q[sel_rd];
          timer_load  = 1'b1;
          state_d     = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // A coin is banked even when the cycle also ends collection, so
        // it is included in whatever is vended or refunded next.
        if (coin_valid && coin_ok) begin
          credit_d   = coin_sum[PRICE_W-1:0];
          timer_load = 1'b1;
        end else begin
          timer_dec = 1'b1;
          if (coin_valid) begin
            coin_rej_d = 1'b1;
          end
        end

        // Confirm is judged on the credit held before this cycle's coin.
        if (srst || cancel || timer_zero) begin
          state_d = S_REFUND;
        end else if (confirm) begin
          if (credit_q >= price_out_q) begin
            state_d = S_VEND;
          end else begin
            status_d = ST_INSUFFICIENT;
          end
        end
      end

      S_VEND: begin
        vend_valid_d = 1'b1;
        vend_idx_d   = sel_q;
        if (!stock_dec[SW]) begin
          stock_d[sel_rd] = stock_dec[SW-1:0];
        end
        if (change_pos) begin
          change_valid_d = 1'b1;
          change_amt_d   = change_diff[PRICE_W-1:0];
        end
        credit_d = '0;
        status_d = ST_NONE;
        state_d  = S_IDLE;
      end

      S_REFUND: begin
        if (credit_q != '0) begin
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
        end
        credit_d = '0;
        status_d = ST_NONE;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Controller state and registered outputs; reset drops any pending pulse.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q        <= S_IDLE;
      status_q       <= ST_NONE;
      sel_q          <= '0;
      price_out_q    <= '0;
      credit_q       <= '0;
      change_amt_q   <= '0;
      vend_idx_q     <= '0;
      coin_rej_q     <= 1'b0;
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      restock_ack_q  <= 1'b0;
      restock_err_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      status_q       <= status_d;
      sel_q          <= sel_d;
      price_out_q    <= price_out_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      vend_idx_q     <= vend_idx_d;
      coin_rej_q     <= coin_rej_d;
      vend_valid_q   <= vend_valid_d;
      change_valid_q <= change_valid_d;
      restock_ack_q  <= restock_ack_d;
      restock_err_q  <= restock_err_d;
      busy_q         <= busy_d;
    end
  end

  // Stock and price tables; every slot starts empty at the default price.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= '0;
        price_q[i] <= PRICE_W'(DEFAULT_PRICE);
      end
    end else begin
      stock_q <= stock_d;
      price_q <= price_d;
    end
  end

  assign status       = status_q;
  assign price_out    = price_out_q;
  assign credit       = credit_q;
  assign coin_rej     = coin_rej_q;
  assign vend_valid   = vend_valid_q;
  assign vend_idx     = vend_idx_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign restock_ack  = restock_ack_q;
  assign restock_err  = restock_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vm_ctrl_param.sv
// Directed bench for vm_ctrl_param with hand-computed expectations.
module tb_vm_ctrl_param;

  localparam int N_ITEMS       = 8;
  localparam int CAP           = 16;
  localparam int PRICE_W       = 16;
  localparam int TIMEOUT       = 255;
  localparam int DEFAULT_PRICE = 50;
  localparam int IW            = 3;
  localparam int SW            = 5;

  logic               clk = 1'b0;
  logic               hrst_n = 1'b0;
  logic               srst = 1'b0;
  logic               sel_valid = 1'b0;
  logic [IW-1:0]      sel_idx = '0;
  logic               coin_valid = 1'b0;
  logic [1:0]         coin = '0;
  logic               confirm = 1'b0;
  logic               cancel = 1'b0;
  logic               restock_valid = 1'b0;
  logic [IW-1:0]      restock_idx = '0;
  logic [SW-1:0]      restock_count = '0;
  logic [PRICE_W-1:0] restock_price = '0;
  logic [1:0]         status;
  logic [PRICE_W-1:0] price_out;
  logic [PRICE_W-1:0] credit;
  logic               coin_rej;
  logic               vend_valid;
  logic [IW-1:0]      vend_idx;
  logic               change_valid;
  logic [PRICE_W-1:0] change_amt;
  logic               restock_ack;
  logic               restock_err;
  logic               busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  vm_ctrl_param #(
    .N_ITEMS       (N_ITEMS),
    .CAP           (CAP),
    .PRICE_W       (PRICE_W),
    .TIMEOUT       (TIMEOUT),
    .DEFAULT_PRICE (DEFAULT_PRICE)
  ) dut (
    .clk           (clk),
    .hrst_n        (hrst_n),
    .srst          (srst),
    .sel_valid     (sel_valid),
    .sel_idx       (sel_idx),
    .coin_valid    (coin_valid),
    .coin          (coin),
    .confirm       (confirm),
    .cancel        (cancel),
    .restock_valid (restock_valid),
    .restock_idx   (restock_idx),
    .restock_count (restock_count),
    .restock_price (restock_price),
    .status        (status),
    .price_out     (price_out),
    .credit        (credit),
    .coin_rej      (coin_rej),
    .vend_valid    (vend_valid),
    .vend_idx      (vend_idx),
    .change_valid  (change_valid),
    .change_amt    (change_amt),
    .restock_ack   (restock_ack),
    .restock_err   (restock_err),
    .busy          (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hold the current inputs across n rising edges, then settle 1 ns past the edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    srst          = 1'b0;
    sel_valid     = 1'b0;
    coin_valid    = 1'b0;
    coin          = '0;
    confirm       = 1'b0;
    cancel        = 1'b0;
    restock_valid = 1'b0;
    restock_count = '0;
    restock_price = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Strobe a selection, then let the CHECK cycle resolve.
  task automatic selectSlot(input logic [IW-1:0] idx);
    sel_valid = 1'b1;
    sel_idx   = idx;
    applyStimulus(1);
    sel_valid = 1'b0;
    applyStimulus(1);
  endtask

  task automatic restockSlot(input logic [IW-1:0] idx, input logic [SW-1:0] cnt,
                             input logic [PRICE_W-1:0] pr);
    restock_valid = 1'b1;
    restock_idx   = idx;
    restock_count = cnt;
    restock_price = pr;
    applyStimulus(1);
    clearInputs();
  endtask

  task automatic insertCoins(input logic [1:0] kind, input int n);
    coin_valid = 1'b1;
    coin       = kind;
    applyStimulus(n);
    coin_valid = 1'b0;
    coin       = '0;
  endtask

  initial begin
    $display("[TB] reset");
    clearInputs();
    hrst_n = 1'b0;
    applyStimulus(2);
    checkOutput("rst_status", 32'(status), 0);
    checkOutput("rst_credit", 32'(credit), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_price_out", 32'(price_out), 0);
    checkOutput("rst_change_amt", 32'(change_amt), 0);
    checkOutput("rst_restock_ack", 32'(restock_ack), 0);
    hrst_n = 1'b1;

    $display("[TB] coin while idle");
    insertCoins(2'd1, 1);
    checkOutput("idle_coin_rej", 32'(coin_rej), 1);
    checkOutput("idle_coin_credit", 32'(credit), 0);
    applyStimulus(1);
    checkOutput("idle_coin_rej_pulse", 32'(coin_rej), 0);

    $display("[TB] restock slot 2 and select it");
    restockSlot(3'd2, 5'd5, 16'd75);
    checkOutput("rs1_ack", 32'(restock_ack), 1);
    checkOutput("rs1_err", 32'(restock_err), 0);
    applyStimulus(1);
    checkOutput("rs1_ack_pulse", 32'(restock_ack), 0);
    selectSlot(3'd2);
    checkOutput("sel2_status", 32'(status), 1);
    checkOutput("sel2_price", 32'(price_out), 75);
    checkOutput("sel2_busy", 32'(busy), 1);
    cancel = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("sel2_cancel_nochange", 32'(change_valid), 0);
    checkOutput("sel2_cancel_busy", 32'(busy), 0);
    checkOutput("sel2_cancel_status", 32'(status), 0);

    $display("[TB] over-capacity restock and empty slot");
    restockSlot(3'd2, 5'd12, 16'd0);
    checkOutput("rs_over_err", 32'(restock_err), 1);
    checkOutput("rs_over_ack", 32'(restock_ack), 0);
    selectSlot(3'd4);
    checkOutput("sel4_status", 32'(status), 2);
    checkOutput("sel4_busy", 32'(busy), 0);

    $display("[TB] vend with change");
    selectSlot(3'd2);
    insertCoins(2'd3, 4);
    checkOutput("q4_credit", 32'(credit), 100);
    confirm = 1'b1;
    applyStimulus(1);
    clearInputs();
    checkOutput("vend_pending_busy", 32'(busy), 1);
    checkOutput("vend_pending_valid", 32'(vend_valid), 0);
    applyStimulus(1);
    checkOutput("vend_valid", 32'(vend_valid), 1);
    checkOutput("vend_idx", 32'(vend_idx), 2);
    checkOutput("vend_change_valid", 32'(change_valid), 1);
    checkOutput("vend_change_amt", 32'(change_amt), 25);
    checkOutput("vend_credit", 32'(credit), 0);
    checkOutput("vend_busy", 32'(busy), 0);
    applyStimulus(1);
    checkOutput("vend_valid_pulse", 32'(vend_valid), 0);
    checkOutput("vend_change_pulse", 32'(change_valid), 0);
    checkOutput("vend_change_hold", 32'(change_amt), 25);
    checkOutput("vend_idx_hold", 32'(vend_idx), 2);

    $display("[TB] insufficient credit then cancel with confirm");
    selectSlot(3'd2);
    insertCoins(2'd2, 1);
    checkOutput("dime_credit", 32'(credit), 10);
    confirm = 1'b1;
    applyStimulus(1);
    checkOutput("insuf_status", 32'(status), 3);
    checkOutput("insuf_busy", 32'(busy), 1);
    cancel = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("cancel_change_valid", 32'(change_valid), 1);
    checkOutput("cancel_change_amt", 32'(change_amt), 10);
    checkOutput("cancel_busy", 32'(busy), 0);
    checkOutput("cancel_status", 32'(status), 0);

    $display("[TB] collection timeout");
    selectSlot(3'd2);
    insertCoins(2'd1, 1);
    applyStimulus(TIMEOUT + 1);
    checkOutput("timeout_early_change", 32'(change_valid), 0);
    checkOutput("timeout_early_busy", 32'(busy), 1);
    applyStimulus(1);
    checkOutput("timeout_change_valid", 32'(change_valid), 1);
    checkOutput("timeout_change_amt", 32'(change_amt), 5);
    checkOutput("timeout_busy", 32'(busy), 0);

    $display("[TB] coins every 200 cycles keep collection alive");
    selectSlot(3'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(199);
      checkOutput("slow_coin_busy", 32'(busy), 1);
      insertCoins(2'd1, 1);
    end
    checkOutput("slow_coin_credit", 32'(credit), 15);
    insertCoins(2'd0, 1);
    checkOutput("bad_coin_rej", 32'(coin_rej), 1);
    checkOutput("bad_coin_credit", 32'(credit), 15);
    srst = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("srst_change_valid", 32'(change_valid), 1);
    checkOutput("srst_change_amt", 32'(change_amt), 15);
    checkOutput("srst_busy", 32'(busy), 0);

    $display("[TB] exact-price vend");
    selectSlot(3'd2);
    insertCoins(2'd3, 3);
    confirm = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("exact_vend_valid", 32'(vend_valid), 1);
    checkOutput("exact_no_change", 32'(change_valid), 0);
    checkOutput("exact_change_hold", 32'(change_amt), 15);
    checkOutput("exact_credit", 32'(credit), 0);

    $display("[TB] restock to capacity and price update");
    restockSlot(3'd2, 5'd13, 16'd0);
    checkOutput("rs_cap_ack", 32'(restock_ack), 1);
    restockSlot(3'd2, 5'd1, 16'd0);
    checkOutput("rs_cap_plus1_err", 32'(restock_err), 1);
    restockSlot(3'd2, 5'd0, 16'd40);
    checkOutput("rs_price_ack", 32'(restock_ack), 1);
    selectSlot(3'd2);
    checkOutput("new_price", 32'(price_out), 40);
    checkOutput("new_price_status", 32'(status), 1);

    $display("[TB] credit overflow and hard reset mid-collection");
    insertCoins(2'd3, 2620);
    checkOutput("big_credit", 32'(credit), 65500);
    insertCoins(2'd2, 2);
    checkOutput("fff0_credit", 32'(credit), 32'hFFF0);
    insertCoins(2'd3, 1);
    checkOutput("ovf_coin_rej", 32'(coin_rej), 1);
    checkOutput("ovf_credit", 32'(credit), 32'hFFF0);
    #2;
    hrst_n = 1'b0;
    #1;
    checkOutput("hrst_credit", 32'(credit), 0);
    checkOutput("hrst_status", 32'(status), 0);
    checkOutput("hrst_busy", 32'(busy), 0);
    checkOutput("hrst_price_out", 32'(price_out), 0);
    checkOutput("hrst_coin_rej", 32'(coin_rej), 0);
    checkOutput("hrst_change_amt", 32'(change_amt), 0);
    checkOutput("hrst_vend_idx", 32'(vend_idx), 0);
    applyStimulus(1);
    hrst_n = 1'b1;

    $display("[TB] tables back to reset contents");
    selectSlot(3'd2);
    checkOutput("post_rst_sel2_status", 32'(status), 2);
    restockSlot(3'd1, 5'd1, 16'd0);
    checkOutput("post_rst_rs_ack", 32'(restock_ack), 1);
    selectSlot(3'd1);
    checkOutput("default_price", 32'(price_out), DEFAULT_PRICE);
    checkOutput("default_price_status", 32'(status), 1);
    cancel = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
